intr_ctrl: RTL and testbench

Interrupt request controller for the RAT MCU: the source end of the interrupt interface whose CPU end is the interrupt-enable flag. It collects rising-edge events from up to eight peripheral lines, holds them as pending bits under a software mask, and drives the single INTR line into the CPU. INTR is held until the control unit's interrupt-cycle acknowledge, after which the source ID of the acknowledged request is available on an IN port until the ISR signals end-of-interrupt.

---
 rtl/rat_intr_pkg.sv | 16 +
 rtl/intr_sync_edge.sv | 30 +++
 rtl/intr_ctrl.sv | 132 +++++++++++++
 tb/tb_intr_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_intr_pkg.sv
// Shared types and helpers for the RAT MCU interrupt request controller.
package rat_intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_e;

   localparam int MAX_SRC = 8;

   function automatic int id_width(input int n);
      id_width = (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Two-flop synchronizer per line followed by a "previous" flop; flags rising edges.
module intr_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] ASYNC_IN,
   output logic [WIDTH-1:0] RISE
);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] prev_r;

   // synchronizer chain and edge history
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_r <= '0;
         sync2_r <= '0;
         prev_r  <= '0;
      end else begin
         sync1_r <= ASYNC_IN;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign RISE = sync2_r & ~prev_r;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt request controller: edge-captured pending bits, software mask,
// fixed lowest-index priority and an IDLE/REQ/SERVICE handshake with the CPU.
module intr_ctrl
   import rat_intr_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = id_width(NUM_SRC)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_SRC-1:0] SRC,
   input  logic               MASK_WE,
   input  logic [NUM_SRC-1:0] MASK_DIN,
   input  logic               EOI,
   input  logic               INT_ACK,
   output logic               INTR,
   output logic [NUM_SRC-1:0] PEND,
   output logic [NUM_SRC-1:0] MASK,
   output logic [ID_W-1:0]    ACTIVE_ID
);

   logic [NUM_SRC-1:0] rise_s;
   logic [NUM_SRC-1:0] req_s;
   logic [NUM_SRC-1:0] clr_s;
   logic               req_any_s;
   logic               ack_fire_s;
   logic [ID_W-1:0]    win_s;

   logic [NUM_SRC-1:0] pend_r;
   logic [NUM_SRC-1:0] mask_r;
   logic               intr_r;
   logic [ID_W-1:0]    active_id_r;
   intr_state_e        state_r;

   // Lowest set index wins; scanning downward leaves the lowest hit last.
   function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
      prio_enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         prio_enc = v[i] ? ID_W'(i) : prio_enc;
      end
   endfunction

   intr_sync_edge #(
      .WIDTH (NUM_SRC)
   ) u_sync_edge (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .ASYNC_IN (SRC),
      .RISE     (rise_s)
   );

   // eligible requests, winner and the one-hot clear for an accepted acknowledge
   always_comb begin
      req_s      = pend_r & mask_r;
      req_any_s  = |req_s;
      win_s      = prio_enc(req_s);
      ack_fire_s = (state_r == ST_REQ) && INT_ACK && req_any_s;
      clr_s      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_s[i] = ack_fire_s && (win_s == ID_W'(i));
      end
   end

   // pending bits (a same-cycle set beats the clear) and the mask register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend_r <= '0;
         mask_r <= '0;
      end else begin
         pend_r <= (pend_r & ~clr_s) | rise_s;
         if (MASK_WE) begin
            mask_r <= MASK_DIN;
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   // request handshake FSM with registered INTR and ACTIVE_ID
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r     <= ST_IDLE;
         intr_r      <= 1'b0;
         active_id_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_any_s) begin
                  state_r <= ST_REQ;
                  intr_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  intr_r  <= 1'b0;
               end
            end
            ST_REQ: begin
               if (ack_fire_s) begin
                  state_r     <= ST_SERVICE;
                  intr_r      <= 1'b0;
                  active_id_r <= win_s;
               end else if (!req_any_s) begin
                  // mask withdrew every eligible request before the CPU took it
                  state_r <= ST_IDLE;
                  intr_r  <= 1'b0;
               end else begin
                  state_r <= ST_REQ;
                  intr_r  <= 1'b1;
               end
            end
            ST_SERVICE: begin
               intr_r <= 1'b0;
               if (EOI) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_SERVICE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               intr_r      <= 1'b0;
               active_id_r <= '0;
            end
         endcase
      end
   end

   assign INTR      = intr_r;
   assign PEND      = pend_r;
   assign MASK      = mask_r;
   assign ACTIVE_ID = active_id_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_intr_ctrl;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [N-1:0]  SRC;
   logic          MASK_WE;
   logic [N-1:0]  MASK_DIN;
   logic          EOI;
   logic          INT_ACK;
   logic          INTR;
   logic [N-1:0]  PEND;
   logic [N-1:0]  MASK;
   logic [IW-1:0] ACTIVE_ID;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [N-1:0]  m_pend;
   logic [N-1:0]  m_mask;
   logic          m_intr;
   logic          m_serv;
   logic [IW-1:0] m_id;
   logic [N-1:0]  m_hist[$];

   intr_ctrl #(.NUM_SRC(N), .ID_W(IW)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .SRC       (SRC),
      .MASK_WE   (MASK_WE),
      .MASK_DIN  (MASK_DIN),
      .EOI       (EOI),
      .INT_ACK   (INT_ACK),
      .INTR      (INTR),
      .PEND      (PEND),
      .MASK      (MASK),
      .ACTIVE_ID (ACTIVE_ID)
   );

   always #5 CLK = ~CLK;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_mask = '0;
      m_intr = 1'b0;
      m_serv = 1'b0;
      m_id   = '0;
      m_hist.delete();
      repeat (3) m_hist.push_back('0);
   endtask

   // One clock edge of the model: m_hist[k] is SRC sampled k+1 edges ago.
   task automatic model_step();
      logic [N-1:0] set_v, req_v, clr_v;
      int w;
      set_v = m_hist[1] & ~m_hist[2];
      req_v = m_pend & m_mask;
      clr_v = '0;
      if (m_intr) begin
         if (req_v == '0) begin
            m_intr = 1'b0;
         end else if (INT_ACK) begin
            w        = lowest(req_v);
            m_id     = IW'(w);
            clr_v[w] = 1'b1;
            m_intr   = 1'b0;
            m_serv   = 1'b1;
         end
      end else if (m_serv) begin
         if (EOI) m_serv = 1'b0;
      end else if (req_v != '0) begin
         m_intr = 1'b1;
      end
      m_pend = (m_pend & ~clr_v) | set_v;
      if (MASK_WE) m_mask = MASK_DIN;
      m_hist.push_front(SRC);
      void'(m_hist.pop_back());
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      MASK_WE = 1'b0;
      EOI     = 1'b0;
      INT_ACK = 1'b0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0; SRC = '0; MASK_WE = 1'b0; MASK_DIN = '0; EOI = 1'b0; INT_ACK = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic set_mask(input logic [N-1:0] v);
      MASK_WE = 1'b1; MASK_DIN = v;
      tick();
   endtask

   task automatic test_reset();
      RST_N = 1'b0; MASK_WE = 1'b0; MASK_DIN = '0; EOI = 1'b0; INT_ACK = 1'b0;
      for (int i = 0; i < 4; i++) begin
         SRC = N'($urandom);
         @(posedge CLK); #1;
      end
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL reset_intr: got %b expected 0", INTR); end
      tests++; if (PEND !== 8'h00) begin fails++; $display("FAIL reset_pend: got %h expected 00", PEND); end
      tests++; if (MASK !== 8'h00) begin fails++; $display("FAIL reset_mask: got %h expected 00", MASK); end
      tests++; if (ACTIVE_ID !== 3'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", ACTIVE_ID); end
      SRC = '0;
      RST_N = 1'b1;
      model_reset();
      tick(); tick();
      SRC = 8'h04;
      repeat (4) tick();
      tests++; if (PEND !== 8'h04) begin fails++; $display("FAIL reset_masked_pend: got %h expected 04", PEND); end
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL reset_masked_intr: got %b expected 0", INTR); end
      SRC = '0;
   endtask

   task automatic test_basic();
      do_reset();
      set_mask(8'hFF);
      SRC = 8'h20;
      repeat (3) tick();
      tests++; if (PEND !== 8'h20) begin fails++; $display("FAIL basic_pend_k2: got %h expected 20", PEND); end
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL basic_intr_k2: got %b expected 0", INTR); end
      tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL basic_intr_k3: got %b expected 1", INTR); end
      INT_ACK = 1'b1; tick();
      tests++; if (ACTIVE_ID !== 3'd5) begin fails++; $display("FAIL basic_ack_id: got %0d expected 5", ACTIVE_ID); end
      tests++; if (PEND !== 8'h00) begin fails++; $display("FAIL basic_ack_pend: got %h expected 00", PEND); end
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL basic_ack_intr: got %b expected 0", INTR); end
      SRC = '0;
      EOI = 1'b1; tick(); tick();
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL basic_eoi_intr: got %b expected 0", INTR); end
   endtask

   task automatic test_priority();
      do_reset();
      set_mask(8'hFF);
      SRC = 8'h42;
      repeat (4) tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL prio_intr: got %b expected 1", INTR); end
      INT_ACK = 1'b1; tick();
      tests++; if (ACTIVE_ID !== 3'd1) begin fails++; $display("FAIL prio_first_id: got %0d expected 1", ACTIVE_ID); end
      tests++; if (PEND !== 8'h40) begin fails++; $display("FAIL prio_first_pend: got %h expected 40", PEND); end
      EOI = 1'b1; tick();
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL prio_eoi_intr: got %b expected 0", INTR); end
      tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL prio_reassert: got %b expected 1", INTR); end
      INT_ACK = 1'b1; tick();
      tests++; if (ACTIVE_ID !== 3'd6) begin fails++; $display("FAIL prio_second_id: got %0d expected 6", ACTIVE_ID); end
      tests++; if (PEND !== 8'h00) begin fails++; $display("FAIL prio_second_pend: got %h expected 00", PEND); end
      SRC = '0;
      EOI = 1'b1; tick();
   endtask

   task automatic test_collision();
      do_reset();
      set_mask(8'hFF);
      SRC = 8'h08;
      repeat (4) tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL coll_intr: got %b expected 1", INTR); end
      SRC = '0; tick(); tick();
      SRC = 8'h08; tick(); tick();
      INT_ACK = 1'b1; tick();
      tests++; if (ACTIVE_ID !== 3'd3) begin fails++; $display("FAIL coll_id: got %0d expected 3", ACTIVE_ID); end
      tests++; if (PEND !== 8'h08) begin fails++; $display("FAIL coll_pend: got %h expected 08", PEND); end
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL coll_ack_intr: got %b expected 0", INTR); end
      EOI = 1'b1; tick(); tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL coll_reassert: got %b expected 1", INTR); end
      SRC = '0;
      INT_ACK = 1'b1; tick();
      EOI = 1'b1; tick();
   endtask

   task automatic test_mask_withdraw();
      do_reset();
      set_mask(8'hFF);
      SRC = 8'h10;
      repeat (4) tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL mask_intr: got %b expected 1", INTR); end
      set_mask(8'hEF);
      tests++; if (MASK !== 8'hEF) begin fails++; $display("FAIL mask_value: got %h expected ef", MASK); end
      tick();
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL mask_drop_intr: got %b expected 0", INTR); end
      tests++; if (PEND !== 8'h10) begin fails++; $display("FAIL mask_drop_pend: got %h expected 10", PEND); end
      tick(); tick();
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL mask_idle_intr: got %b expected 0", INTR); end
      set_mask(8'hFF);
      tick();
      tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL mask_restore_intr: got %b expected 1", INTR); end
      SRC = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      set_mask(8'hFF);
      SRC = 8'h06;
      repeat (4) tick();
      INT_ACK = 1'b1; tick();
      tests++; if (ACTIVE_ID !== 3'd1) begin fails++; $display("FAIL arst_pre_id: got %0d expected 1", ACTIVE_ID); end
      tests++; if (PEND !== 8'h04) begin fails++; $display("FAIL arst_pre_pend: got %h expected 04", PEND); end
      #2 RST_N = 1'b0;
      #1;
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL arst_intr: got %b expected 0", INTR); end
      tests++; if (PEND !== 8'h00) begin fails++; $display("FAIL arst_pend: got %h expected 00", PEND); end
      tests++; if (MASK !== 8'h00) begin fails++; $display("FAIL arst_mask: got %h expected 00", MASK); end
      tests++; if (ACTIVE_ID !== 3'd0) begin fails++; $display("FAIL arst_id: got %0d expected 0", ACTIVE_ID); end
      @(posedge CLK); #1;
      SRC = '0;
      RST_N = 1'b1;
      model_reset();
      EOI = 1'b1; tick(); tick();
      tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL arst_eoi_intr: got %b expected 0", INTR); end
      tests++; if (ACTIVE_ID !== 3'd0) begin fails++; $display("FAIL arst_eoi_id: got %0d expected 0", ACTIVE_ID); end
      tests++; if (PEND !== 8'h00) begin fails++; $display("FAIL arst_eoi_pend: got %h expected 00", PEND); end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      set_mask(N'($urandom));
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 3 == 0) SRC = N'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            MASK_WE  = 1'b1;
            MASK_DIN = N'($urandom);
         end
         INT_ACK = m_intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         EOI     = m_serv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         tick();
         tests++;
         if (INTR !== m_intr) begin
            fails++; errs++;
            if (errs < 10) $display("FAIL rand_intr cyc %0d: got %b expected %b", cyc, INTR, m_intr);
         end
         tests++;
         if (PEND !== m_pend) begin
            fails++; errs++;
            if (errs < 10) $display("FAIL rand_pend cyc %0d: got %h expected %h", cyc, PEND, m_pend);
         end
         tests++;
         if (MASK !== m_mask) begin
            fails++; errs++;
            if (errs < 10) $display("FAIL rand_mask cyc %0d: got %h expected %h", cyc, MASK, m_mask);
         end
         tests++;
         if (ACTIVE_ID !== m_id) begin
            fails++; errs++;
            if (errs < 10) $display("FAIL rand_id cyc %0d: got %0d expected %0d", cyc, ACTIVE_ID, m_id);
         end
      end
      SRC = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_priority();
      test_collision();
      test_mask_withdraw();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
